// File: rtl/cnn_feed_scheduler.sv
// Job sequencer for the CNN block: latches a job, loads filter then IFmap words from
// a 1-cycle-latency memory under back-pressure, and drains results to a ready/valid stream.
module cnn_feed_scheduler #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = 10,
  parameter int CFG_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  go,
  input  logic [ADDR_WIDTH-1:0] cfg_filter_base,
  input  logic [ADDR_WIDTH-1:0] cfg_if_base,
  input  logic [CNT_WIDTH-1:0]  cfg_filter_words,
  input  logic [CNT_WIDTH-1:0]  cfg_if_words,
  input  logic [CNT_WIDTH-1:0]  cfg_result_words,
  input  logic [CFG_WIDTH-1:0]  cfg_stride,
  input  logic [CFG_WIDTH-1:0]  cfg_filter_size,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  cnn_start,
  output logic [CFG_WIDTH-1:0]  cnn_stride,
  output logic [CFG_WIDTH-1:0]  cnn_filter_size,
  output logic [DATA_WIDTH-1:0] filter_buffer_in,
  output logic                  filter_buffer_write_enable,
  input  logic                  filter_buffer_full,
  output logic [DATA_WIDTH-1:0] IFmap_buffer_in,
  output logic                  IFmap_buffer_write_enable,
  input  logic                  IFmap_buffer_full,
  input  logic [DATA_WIDTH-1:0] result_buffer_out,
  input  logic                  result_buffer_empty,
  output logic                  result_buffer_read_enable,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_FETCH_F, S_WRITE_F, S_FETCH_I, S_WRITE_I, S_DRAIN_WAIT, S_FINISH
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] filter_base, if_base, idx_addr;
  logic [CNT_WIDTH-1:0]  filter_words, if_words, result_words;
  logic [CNT_WIDTH-1:0]  index, res_count;
  logic                  in_job, fetch_f, fetch_i, pop, res_done, cfg_zero;

  // Memory reads are only issued while the target buffer has room, so the single
  // outstanding word can always be written the following cycle without a recheck.
  always_comb begin
    in_job   = (state != S_IDLE);
    fetch_f  = (state == S_FETCH_F) && !filter_buffer_full;
    fetch_i  = (state == S_FETCH_I) && !IFmap_buffer_full;
    pop      = in_job && !result_buffer_empty && (res_count < result_words) &&
               (!res_valid || res_ready);
    res_done = (res_count == result_words) && (!res_valid || res_ready);
    cfg_zero = (cfg_filter_words == '0) || (cfg_if_words == '0) || (cfg_result_words == '0);
    idx_addr = ADDR_WIDTH'(index);
  end

  assign mem_rd   = fetch_f || fetch_i;
  assign mem_addr = fetch_f ? filter_base + idx_addr :
                    fetch_i ? if_base + idx_addr : '0;

  assign filter_buffer_write_enable = (state == S_WRITE_F);
  assign filter_buffer_in           = filter_buffer_write_enable ? mem_rdata : '0;
  assign IFmap_buffer_write_enable  = (state == S_WRITE_I);
  assign IFmap_buffer_in            = IFmap_buffer_write_enable ? mem_rdata : '0;
  assign result_buffer_read_enable  = pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      filter_base     <= '0;
      if_base         <= '0;
      filter_words    <= '0;
      if_words        <= '0;
      result_words    <= '0;
      index           <= '0;
      res_count       <= '0;
      cnn_stride      <= '0;
      cnn_filter_size <= '0;
      cnn_start       <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
      res_valid       <= 1'b0;
      res_data        <= '0;
    end else begin
      done      <= 1'b0;
      cnn_start <= 1'b0;

      // Result drain overlaps the whole job; a pop refills the output register
      // in the same cycle the previous word is accepted.
      if (pop) begin
        res_data  <= result_buffer_out;
        res_valid <= 1'b1;
        res_count <= res_count + CNT_ONE;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (go) begin
            filter_base     <= cfg_filter_base;
            if_base         <= cfg_if_base;
            filter_words    <= cfg_filter_words;
            if_words        <= cfg_if_words;
            result_words    <= cfg_result_words;
            cnn_stride      <= cfg_stride;
            cnn_filter_size <= cfg_filter_size;
            err             <= cfg_zero;
            index           <= '0;
            res_count       <= '0;
            if (cfg_zero) begin
              done <= 1'b1;
            end else begin
              state     <= S_START;
              cnn_start <= 1'b1;
              busy      <= 1'b1;
            end
          end
        end
        S_START: state <= S_FETCH_F;
        S_FETCH_F: if (!filter_buffer_full) state <= S_WRITE_F;
        S_WRITE_F: begin
          if (index == filter_words - CNT_ONE) begin
            index <= '0;
            state <= S_FETCH_I;
          end else begin
            index <= index + CNT_ONE;
            state <= S_FETCH_F;
          end
        end
        S_FETCH_I: if (!IFmap_buffer_full) state <= S_WRITE_I;
        S_WRITE_I: begin
          if (index == if_words - CNT_ONE) begin
            index <= '0;
            state <= S_DRAIN_WAIT;
          end else begin
            index <= index + CNT_ONE;
            state <= S_FETCH_I;
          end
        end
        // Leave as soon as the last result is being accepted so done follows the final handshake.
        S_DRAIN_WAIT: begin
          if (res_done) begin
            done  <= 1'b1;
            state <= S_FINISH;
          end
        end
        S_FINISH: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_feed_scheduler.sv
// Self-checking bench for cnn_feed_scheduler: table of job configs plus random jobs,
// checked against a word-order model of memory, write ports and the result stream.
module tb_cnn_feed_scheduler;

  logic       clk = 1'b0;
  logic       reset, go;
  logic [9:0] cfg_filter_base, cfg_if_base, cfg_filter_words, cfg_if_words, cfg_result_words;
  logic [7:0] cfg_stride, cfg_filter_size;
  logic       mem_rd;
  logic [9:0] mem_addr;
  logic [7:0] mem_rdata;
  logic       cnn_start;
  logic [7:0] cnn_stride, cnn_filter_size;
  logic [7:0] filter_buffer_in, IFmap_buffer_in, result_buffer_out, res_data;
  logic       filter_buffer_write_enable, filter_buffer_full;
  logic       IFmap_buffer_write_enable, IFmap_buffer_full;
  logic       result_buffer_empty, result_buffer_read_enable;
  logic       res_valid, res_ready, busy, done, err;

  always #5 clk = ~clk;

  cnn_feed_scheduler #(.DATA_WIDTH(8), .ADDR_WIDTH(10), .CNT_WIDTH(10), .CFG_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .go(go),
    .cfg_filter_base(cfg_filter_base), .cfg_if_base(cfg_if_base),
    .cfg_filter_words(cfg_filter_words), .cfg_if_words(cfg_if_words),
    .cfg_result_words(cfg_result_words), .cfg_stride(cfg_stride),
    .cfg_filter_size(cfg_filter_size), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .cnn_start(cnn_start), .cnn_stride(cnn_stride),
    .cnn_filter_size(cnn_filter_size), .filter_buffer_in(filter_buffer_in),
    .filter_buffer_write_enable(filter_buffer_write_enable),
    .filter_buffer_full(filter_buffer_full), .IFmap_buffer_in(IFmap_buffer_in),
    .IFmap_buffer_write_enable(IFmap_buffer_write_enable),
    .IFmap_buffer_full(IFmap_buffer_full), .result_buffer_out(result_buffer_out),
    .result_buffer_empty(result_buffer_empty),
    .result_buffer_read_enable(result_buffer_read_enable),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .busy(busy), .done(done), .err(err)
  );

  typedef struct {
    int fbase, ibase, fw, iw, rw, stride, fsize;
    int full_pct, ready_pct, res_mode, f_stall, ready_low;
    bit exp_err;
    int exp_starts, exp_fw, exp_iw, exp_res;
  } vec_t;

  int         checks = 0, errors = 0;
  logic [7:0] mem_model [1024];
  logic [7:0] result_q[$], exp_res_q[$];
  vec_t       vecs[$];
  vec_t       cur;
  int         cyc = 0, job_cyc = 0;
  int         f_rd, i_rd, f_wr, i_wr, pops, hs, starts, dones, pushed;
  int         go_cyc, done_cyc, last_hs_cyc, last_wr_cyc, stall_cnt, stall_writes;
  logic [7:0] pend_rdata = 8'h00, held_data;
  logic       held = 1'b0, stall_now = 1'b0, job_active = 1'b0;
  logic       reset_on_ifwrite = 1'b0, reset_fired = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(int fbase, int ibase, int fw, int iw, int rw,
                              int full_pct, int ready_pct, int res_mode, int f_stall, int ready_low);
    vec_t v;
    v.fbase = fbase; v.ibase = ibase; v.fw = fw; v.iw = iw; v.rw = rw;
    v.stride = int'($urandom_range(1, 255)); v.fsize = int'($urandom_range(1, 255));
    v.full_pct = full_pct; v.ready_pct = ready_pct; v.res_mode = res_mode;
    v.f_stall = f_stall; v.ready_low = ready_low;
    v.exp_err    = (fw == 0) || (iw == 0) || (rw == 0);
    v.exp_starts = v.exp_err ? 0 : 1;
    v.exp_fw     = v.exp_err ? 0 : fw;
    v.exp_iw     = v.exp_err ? 0 : iw;
    v.exp_res    = v.exp_err ? 0 : rw;
    return v;
  endfunction

  task automatic pushResult();
    logic [7:0] b;
    b = 8'($urandom);
    result_q.push_back(b);
    if (pushed < cur.rw) exp_res_q.push_back(b);
    pushed++;
  endtask

  task automatic updateResultPort();
    result_buffer_empty = (result_q.size() == 0);
    result_buffer_out   = result_buffer_empty ? 8'($urandom) : result_q[0];
  endtask

  task automatic applyStimulus();
    logic push_ok;
    go        = 1'b0;
    mem_rdata = pend_rdata;
    stall_now = 1'b0;
    if (cur.f_stall > 0 && f_wr >= 2 && stall_cnt < cur.f_stall) begin
      filter_buffer_full = 1'b1;
      stall_cnt++;
      stall_now = 1'b1;
    end else begin
      filter_buffer_full = (int'($urandom_range(99)) < cur.full_pct);
    end
    IFmap_buffer_full = (int'($urandom_range(99)) < cur.full_pct);
    if (cur.ready_low > 0 && job_cyc < cur.ready_low) res_ready = 1'b0;
    else res_ready = (int'($urandom_range(99)) < cur.ready_pct);
    if (job_active && !cur.exp_err && pushed < cur.rw + 2) begin
      push_ok = 1'b0;
      if (cur.res_mode == 0) push_ok = ($urandom_range(2) == 0);
      else if (cur.res_mode == 1) push_ok = (i_wr == cur.iw) && ($urandom_range(1) == 0);
      if (push_ok) pushResult();
    end
    updateResultPort();
  endtask

  task automatic sampleOutputs();
    if (mem_rd) begin
      if (f_rd < cur.fw) begin
        checkOutput("filter_addr", 32'(mem_addr), (cur.fbase + f_rd) % 1024);
        checkOutput("rd_while_filter_full", 32'(filter_buffer_full), 0);
        f_rd++;
      end else begin
        checkOutput("ifmap_addr", 32'(mem_addr), (cur.ibase + i_rd) % 1024);
        checkOutput("rd_while_ifmap_full", 32'(IFmap_buffer_full), 0);
        i_rd++;
      end
      pend_rdata = mem_model[mem_addr];
    end
    if (filter_buffer_write_enable) begin
      checkOutput("filter_data", 32'(filter_buffer_in), 32'(mem_model[(cur.fbase + f_wr) % 1024]));
      checkOutput("filter_overrun", 32'(f_wr < cur.fw), 1);
      if (stall_now) stall_writes++;
      f_wr++;
      last_wr_cyc = cyc;
    end
    if (IFmap_buffer_write_enable) begin
      checkOutput("ifmap_before_filter_done", 32'(f_wr == cur.fw), 1);
      checkOutput("ifmap_data", 32'(IFmap_buffer_in), 32'(mem_model[(cur.ibase + i_wr) % 1024]));
      checkOutput("ifmap_overrun", 32'(i_wr < cur.iw), 1);
      i_wr++;
      last_wr_cyc = cyc;
      if (reset_on_ifwrite && i_wr == 2) begin
        reset       = 1'b1;
        reset_fired = 1'b1;
        job_active  = 1'b0;
      end
    end
    if (result_buffer_read_enable) begin
      checkOutput("pop_when_empty", 32'(result_buffer_empty), 0);
      checkOutput("pop_beyond_count", 32'(pops < cur.rw), 1);
      pops++;
      if (result_q.size() > 0) void'(result_q.pop_front());
    end
    if (held) begin
      checkOutput("res_valid_held", 32'(res_valid), 1);
      checkOutput("res_data_held", 32'(res_data), 32'(held_data));
    end
    held      = res_valid && !res_ready && !reset_fired;
    held_data = res_data;
    if (res_valid && res_ready) begin
      checkOutput("res_data_order", 32'(res_data),
                  (exp_res_q.size() > 0) ? 32'(exp_res_q.pop_front()) : 32'h100);
      hs++;
      last_hs_cyc = cyc;
    end
    if (cnn_start) begin
      starts++;
      checkOutput("start_timing", cyc, go_cyc + 1);
      checkOutput("cnn_stride", 32'(cnn_stride), cur.stride);
      checkOutput("cnn_filter_size", 32'(cnn_filter_size), cur.fsize);
    end
    if (cur.ready_low > 0 && job_cyc == cur.ready_low - 1) begin
      checkOutput("stalled_pop_count", pops, 1);
      checkOutput("stalled_res_valid", 32'(res_valid), 1);
    end
    if (done) begin
      dones++;
      done_cyc = cyc;
      checkOutput("busy_at_done", 32'(busy), cur.exp_err ? 0 : 1);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    sampleOutputs();
    @(posedge clk);
    #1;
    cyc++;
    job_cyc++;
    applyStimulus();
  endtask

  task automatic checkResetState(input string name);
    checkOutput(name, {busy, done, err, cnn_start, mem_rd, filter_buffer_write_enable,
                       IFmap_buffer_write_enable, result_buffer_read_enable, res_valid},  0);
    checkOutput({name, "_data"}, {mem_addr, filter_buffer_in, IFmap_buffer_in}, 0);
    checkOutput({name, "_regs"}, {res_data, cnn_stride, cnn_filter_size}, 0);
  endtask

  task automatic run_job(input vec_t v);
    int n, exp_done;
    cur = v;
    f_rd = 0; i_rd = 0; f_wr = 0; i_wr = 0; pops = 0; hs = 0; starts = 0; dones = 0;
    pushed = 0; stall_cnt = 0; stall_writes = 0; last_hs_cyc = 0; last_wr_cyc = 0; done_cyc = 0;
    result_q.delete();
    exp_res_q.delete();
    cfg_filter_base  = 10'(v.fbase);  cfg_if_base  = 10'(v.ibase);
    cfg_filter_words = 10'(v.fw);     cfg_if_words = 10'(v.iw);
    cfg_result_words = 10'(v.rw);
    cfg_stride       = 8'(v.stride);  cfg_filter_size = 8'(v.fsize);
    go         = 1'b1;
    go_cyc     = cyc;
    job_cyc    = 0;
    job_active = 1'b1;
    if (v.res_mode == 2 && !v.exp_err) for (int k = 0; k < v.rw + 2; k++) pushResult();
    updateResultPort();
    cycle();
    // Scramble the config inputs so only latched values can satisfy the checks.
    {cfg_filter_base, cfg_if_base, cfg_filter_words, cfg_if_words} = 40'($urandom);
    {cfg_result_words, cfg_stride, cfg_filter_size} = 26'($urandom);
    n = 0;
    while (dones == 0 && n < 4000 && !reset_fired) begin
      cycle();
      n++;
    end
    if (reset_fired) return;
    checkOutput("job_completed", 32'(dones > 0), 1);
    for (int k = 0; k < 3; k++) cycle();
    job_active = 1'b0;
    checkOutput("done_count", dones, 1);
    checkOutput("start_count", starts, v.exp_starts);
    checkOutput("filter_writes", f_wr, v.exp_fw);
    checkOutput("ifmap_writes", i_wr, v.exp_iw);
    checkOutput("filter_reads", f_rd, v.exp_fw);
    checkOutput("ifmap_reads", i_rd, v.exp_iw);
    checkOutput("results_out", hs, v.exp_res);
    checkOutput("err_flag", 32'(err), 32'(v.exp_err));
    checkOutput("busy_after", 32'(busy), 0);
    checkOutput("stride_held", 32'(cnn_stride), v.stride);
    if (v.exp_err) begin
      checkOutput("err_done_timing", done_cyc, go_cyc + 1);
    end else begin
      exp_done = (last_hs_cyc + 1 > last_wr_cyc + 2) ? last_hs_cyc + 1 : last_wr_cyc + 2;
      checkOutput("done_timing", done_cyc, exp_done);
    end
    if (v.f_stall > 0) begin
      checkOutput("stall_applied", stall_cnt, v.f_stall);
      checkOutput("writes_during_stall", 32'(stall_writes <= 1), 1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t v;
    for (int a = 0; a < 1024; a++) mem_model[a] = 8'($urandom);
    cur = mk(0, 0, 1, 1, 1, 0, 100, 0, 0, 0);
    reset = 1'b1; go = 1'b0; mem_rdata = '0; res_ready = 1'b0;
    filter_buffer_full = 1'b0; IFmap_buffer_full = 1'b0;
    result_buffer_empty = 1'b1; result_buffer_out = '0;
    {cfg_filter_base, cfg_if_base, cfg_filter_words, cfg_if_words, cfg_result_words} = '0;
    cfg_stride = '0; cfg_filter_size = '0;
    repeat (3) @(posedge clk);
    #1;
    checkResetState("reset_state");
    reset = 1'b0;

    vecs.push_back(mk(10'h040, 10'h100, 4, 9, 4,  0, 100, 1, 0,  0));
    vecs.push_back(mk(10'h200, 10'h300, 8, 5, 3,  0, 100, 0, 10, 0));
    vecs.push_back(mk(10'h010, 10'h020, 1, 1, 3,  0, 100, 2, 0, 12));
    vecs.push_back(mk(10'h050, 10'h060, 3, 0, 2,  0, 100, 0, 0,  0));
    vecs.push_back(mk(10'h050, 10'h060, 0, 3, 2,  0, 100, 0, 0,  0));
    vecs.push_back(mk(10'h050, 10'h060, 3, 3, 0,  0, 100, 0, 0,  0));
    vecs.push_back(mk(10'h080, 1022,    2, 4, 2,  0, 100, 1, 0,  0));
    vecs.push_back(mk(1023,    10'h0F0, 3, 6, 5, 40,  60, 0, 0,  0));
    for (int r = 0; r < 6; r++)
      vecs.push_back(mk(int'($urandom_range(1023)), int'($urandom_range(1023)),
                        int'($urandom_range(1, 16)), int'($urandom_range(1, 16)),
                        int'($urandom_range(1, 12)), int'($urandom_range(0, 50)),
                        int'($urandom_range(30, 100)), int'($urandom_range(0, 1)), 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      $display("[TB] job %0d: filter=%0d ifmap=%0d results=%0d", i, vecs[i].fw, vecs[i].iw, vecs[i].rw);
      run_job(vecs[i]);
    end

    $display("[TB] reset abort during IFmap load");
    reset_on_ifwrite = 1'b1;
    run_job(mk(10'h123, 10'h234, 3, 6, 3, 0, 100, 0, 0, 0));
    checkOutput("reset_fired", 32'(reset_fired), 1);
    checkResetState("abort_state");
    reset = 1'b0;
    reset_on_ifwrite = 1'b0;
    reset_fired = 1'b0;
    dones = 0;
    for (int k = 0; k < 5; k++) cycle();
    checkOutput("no_done_after_abort", dones, 0);
    v = mk(10'h3F0, 10'h010, 5, 7, 4, 20, 80, 0, 0, 0);
    run_job(v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
